// File: rtl/be_data_mem_if.sv
// Load/store request and response bundle for be_data_mem.
interface be_data_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/be_data_mem.sv
// Byte-addressable big-endian data memory: four byte-lane RAMs, clear-after-reset, READ_LAT-deep response pipe.
// Define BE_DATA_MEM_ALIGN_CHECK_EN to turn misaligned half/word accesses into errors.
module be_data_mem #(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1
) (
  input logic          clk,
  input logic          rst,
  be_data_mem_if.slave bus
);
  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int WW     = AW - 2;
  localparam int NWORDS = DEPTH_BYTES / 4;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state_q;
  logic          req_ready_q;
  logic          init_busy_q;
  logic [WW-1:0] clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      req_ready_q <= 1'b0;
      init_busy_q <= 1'b1;
      clr_q       <= '0;
    end else if (state_q == S_CLEAR) begin
      clr_q <= clr_q + 1'b1;
      if (clr_q == WW'(NWORDS - 1)) begin
        state_q     <= S_IDLE;
        req_ready_q <= 1'b1;
        init_busy_q <= 1'b0;
      end
    end
  end

  logic          accept;
  logic [AW-1:0] a_lo;
  logic [1:0]    last_off;
  logic          size_err;
  logic          range_err;
  logic          align_err;
  logic          req_err;

  assign accept = bus.req_valid & req_ready_q & ~rst;
  assign a_lo   = bus.req_addr[AW-1:0];

  always_comb begin
    last_off = 2'd0;
    size_err = 1'b0;
    case (bus.req_size)
      2'b00:   last_off = 2'd0;
      2'b01:   last_off = 2'd1;
      2'b10:   last_off = 2'd3;
      default: size_err = 1'b1;
    endcase
  end

  // Last byte past the end, or any address bit above the array set.
  assign range_err = (({1'b0, a_lo} + (AW + 1)'(last_off)) > (AW + 1)'(DEPTH_BYTES - 1))
                   | ((bus.req_addr >> AW) != '0);

`ifdef BE_DATA_MEM_ALIGN_CHECK_EN
  assign align_err = ((bus.req_size == 2'b01) & a_lo[0])
                   | ((bus.req_size == 2'b10) & (a_lo[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign req_err = size_err | range_err | align_err;

  // Lane gi holds every byte whose address is gi mod 4; offset k of the access maps to lane (A+k) mod 4.
  logic [31:0] lane_rd;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0]    mem [NWORDS];
      logic [7:0]    rd_q;
      logic [1:0]    k;
      logic [WW-1:0] widx;
      logic [7:0]    wbyte;
      logic          st_we;

      assign k     = 2'(gi) - a_lo[1:0];
      assign widx  = WW'((a_lo + AW'(k)) >> 2);
      assign wbyte = 8'(bus.req_wdata >> {last_off - k, 3'b000});
      assign st_we = accept & bus.req_we & ~req_err & (k <= last_off);

      always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
          mem[clr_q] <= 8'h00;
        end else if (st_we) begin
          mem[widx] <= wbyte;
        end
        rd_q <= mem[widx];
      end

      assign lane_rd[8*gi +: 8] = rd_q;
    end
  endgenerate

  logic       s0_valid_q;
  logic       s0_err_q;
  logic       s0_load_q;
  logic       s0_signed_q;
  logic [1:0] s0_off_q;
  logic [1:0] s0_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= accept;
    end
    s0_err_q    <= req_err;
    s0_load_q   <= ~bus.req_we;
    s0_signed_q <= bus.req_signed;
    s0_off_q    <= a_lo[1:0];
    s0_last_q   <= last_off;
  end

  function automatic logic [7:0] pick(input logic [31:0] lanes, input logic [1:0] lane);
    return 8'(lanes >> {lane, 3'b000});
  endfunction

  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rdata_d;

  always_comb begin
    b0      = pick(lane_rd, s0_off_q);
    b1      = pick(lane_rd, s0_off_q + 2'd1);
    b2      = pick(lane_rd, s0_off_q + 2'd2);
    b3      = pick(lane_rd, s0_off_q + 2'd3);
    rdata_d = 32'h0;
    if (s0_load_q & ~s0_err_q) begin
      case (s0_last_q)
        2'd0:    rdata_d = {{24{s0_signed_q & b0[7]}}, b0};
        2'd1:    rdata_d = {{16{s0_signed_q & b0[7]}}, b0, b1};
        default: rdata_d = {b0, b1, b2, b3};
      endcase
    end
  end

  // Stores ride the same pipe as loads so responses never reorder.
  logic        p_valid_q [READ_LAT];
  logic        p_err_q   [READ_LAT];
  logic [31:0] p_data_q  [READ_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        p_valid_q[i] <= 1'b0;
        p_err_q[i]   <= 1'b0;
        p_data_q[i]  <= 32'h0;
      end
    end else begin
      p_valid_q[0] <= s0_valid_q;
      p_err_q[0]   <= s0_valid_q & s0_err_q;
      p_data_q[0]  <= s0_valid_q ? rdata_d : 32'h0;
      for (int i = 1; i < READ_LAT; i++) begin
        p_valid_q[i] <= p_valid_q[i-1];
        p_err_q[i]   <= p_err_q[i-1];
        p_data_q[i]  <= p_data_q[i-1];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.init_busy = init_busy_q;
  assign bus.rsp_valid = p_valid_q[READ_LAT-1];
  assign bus.rsp_err   = p_err_q[READ_LAT-1];
  assign bus.rsp_rdata = p_data_q[READ_LAT-1];
endmodule

// File: tb/tb_be_data_mem.sv
// Directed bench: two 64-byte instances (READ_LAT 2 and 3) driven with identical requests.
`timescale 1ns/1ps
module tb_be_data_mem;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  be_data_mem_if #(.ADDR_W(32)) if2 ();
  be_data_mem_if #(.ADDR_W(32)) if3 ();

  assign if2.req_valid  = req_valid;
  assign if2.req_we     = req_we;
  assign if2.req_size   = req_size;
  assign if2.req_signed = req_signed;
  assign if2.req_addr   = req_addr;
  assign if2.req_wdata  = req_wdata;
  assign if3.req_valid  = req_valid;
  assign if3.req_we     = req_we;
  assign if3.req_size   = req_size;
  assign if3.req_signed = req_signed;
  assign if3.req_addr   = req_addr;
  assign if3.req_wdata  = req_wdata;

  be_data_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .READ_LAT(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  be_data_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .READ_LAT(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds reset for the current edge, checks reset values, then times the clear.
  task automatic finish_reset(input string tag);
    int   busy;
    logic diverge;
    logic stray;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".ready"},  32'({if2.req_ready, if3.req_ready}), 32'h0);
    check({tag, ".valid"},  32'({if2.rsp_valid, if3.rsp_valid}), 32'h0);
    check({tag, ".rdata2"}, if2.rsp_rdata, 32'h0);
    check({tag, ".rdata3"}, if3.rsp_rdata, 32'h0);
    check({tag, ".err"},    32'({if2.rsp_err, if3.rsp_err}), 32'h0);
    check({tag, ".busy"},   32'({if2.init_busy, if3.init_busy}), 32'h3);
    rst     = 1'b0;
    busy    = 0;
    diverge = 1'b0;
    stray   = 1'b0;
    for (int c = 0; c < 200 && if2.init_busy === 1'b1; c++) begin
      busy++;
      if (if3.init_busy !== 1'b1 || if2.req_ready !== 1'b0) diverge = 1'b1;
      if (if2.rsp_valid !== 1'b0 || if3.rsp_valid !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    $display("reset %s: init_busy cycles=%0d", tag, busy);
    check({tag, ".busy_cycles"}, 32'(busy), 32'd16);
    check({tag, ".busy_agree"},  32'(diverge), 32'h0);
    check({tag, ".no_rsp"},      32'(stray), 32'h0);
    check({tag, ".ready_after"}, 32'({if2.req_ready, if3.req_ready, if3.init_busy}), 32'h6);
  endtask

  // One request; watches both instances for up to 7 cycles after acceptance.
  task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err);
    int          lat2, lat3, cnt2, cnt3;
    logic [31:0] d2, d3;
    logic        e2, e3;
    lat2 = -1; lat3 = -1; cnt2 = 0; cnt3 = 0;
    d2 = 'x; d3 = 'x; e2 = 1'bx; e3 = 1'bx;
    check({tag, ".ready"}, 32'({if2.req_ready, if3.req_ready}), 32'h3);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
      if (if2.rsp_valid === 1'b1) begin
        cnt2++;
        if (lat2 < 0) begin lat2 = c; d2 = if2.rsp_rdata; e2 = if2.rsp_err; end
      end
      if (if3.rsp_valid === 1'b1) begin
        cnt3++;
        if (lat3 < 0) begin lat3 = c; d3 = if3.rsp_rdata; e3 = if3.rsp_err; end
      end
    end
    $display("xfer %s: we=%0b size=%0d sgn=%0b addr=0x%08h wdata=0x%08h | L2 lat=%0d rdata=0x%08h err=%0b | L3 lat=%0d rdata=0x%08h err=%0b",
             tag, we, size, sgn, addr, wdata, lat2, d2, e2, lat3, d3, e3);
    check({tag, ".lat2"},  32'(lat2), 32'd2);
    check({tag, ".lat3"},  32'(lat3), 32'd3);
    check({tag, ".cnt2"},  32'(cnt2), 32'd1);
    check({tag, ".cnt3"},  32'(cnt3), 32'd1);
    check({tag, ".data2"}, d2, exp_data);
    check({tag, ".data3"}, d3, exp_data);
    check({tag, ".err2"},  32'(e2), 32'(exp_err));
    check({tag, ".err3"},  32'(e3), 32'(exp_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  m2, m3;
    logic [31:0] d2 [8];
    logic [31:0] d3 [8];
    logic        drop;
    logic        s;
    logic [31:0] e;

    // Clear timing after power-up reset.
    @(posedge clk);
    finish_reset("rst0");
    xfer("clr_w3c", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0);

    // Endianness.
    xfer("st_w10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0);
    xfer("ld_b10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0000_00A1, 1'b0);
    xfer("ld_b11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_00B2, 1'b0);
    xfer("ld_b12",  1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h0000_00C3, 1'b0);
    xfer("ld_b13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_00D4, 1'b0);
    xfer("ld_h12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000_C3D4, 1'b0);
    xfer("ld_sh10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFF_A1B2, 1'b0);

    // Sign / zero extension.
    xfer("st_b05",  1'b1, 2'b00, 1'b0, 32'h05, 32'hFFFF_FF80, 32'h0, 1'b0);
    xfer("ld_sb05", 1'b0, 2'b00, 1'b1, 32'h05, 32'h0, 32'hFFFF_FF80, 1'b0);
    xfer("ld_ub05", 1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 32'h0000_0080, 1'b0);
    xfer("ld_sh04", 1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 32'h0000_0080, 1'b0);

    // Back-to-back store then load of the same word.
    m2 = 8'h0; m3 = 8'h0; drop = 1'b0;
    for (int i = 0; i < 8; i++) begin d2[i] = 'x; d3[i] = 'x; end
    check("b2b.ready0", 32'(if2.req_ready & if3.req_ready), 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h1234_5678;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if2.req_ready !== 1'b1 || if3.req_ready !== 1'b1) drop = 1'b1;
      m2[c] = (if2.rsp_valid === 1'b1);
      m3[c] = (if3.rsp_valid === 1'b1);
      d2[c] = if2.rsp_rdata;
      d3[c] = if3.rsp_rdata;
      if (c == 0) begin req_we = 1'b0; req_wdata = 32'h0; end
      if (c == 1) req_valid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    $display("xfer b2b: L2 valid=%08b st=0x%08h ld=0x%08h | L3 valid=%08b st=0x%08h ld=0x%08h",
             m2, d2[2], d2[3], m3, d3[3], d3[4]);
    check("b2b.mask2",   32'(m2), 32'h0C);
    check("b2b.mask3",   32'(m3), 32'h18);
    check("b2b.st2",     d2[2], 32'h0);
    check("b2b.ld2",     d2[3], 32'h1234_5678);
    check("b2b.st3",     d3[3], 32'h0);
    check("b2b.ld3",     d3[4], 32'h1234_5678);
    check("b2b.noready", 32'(drop), 32'h0);

    // Range, size and address-bit errors.
    xfer("st_w3c",    1'b1, 2'b10, 1'b0, 32'h3C, 32'h1122_3344, 32'h0, 1'b0);
    xfer("st_w3e",    1'b1, 2'b10, 1'b0, 32'h3E, 32'hDEAD_BEEF, 32'h0, 1'b1);
    xfer("ld_w3e",    1'b0, 2'b10, 1'b0, 32'h3E, 32'h0, 32'h0, 1'b1);
    xfer("st_rsv3c",  1'b1, 2'b11, 1'b0, 32'h3C, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xfer("ld_rsv3c",  1'b0, 2'b11, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b1);
    xfer("ld_w3c",    1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h1122_3344, 1'b0);
    xfer("ld_b3f",    1'b0, 2'b00, 1'b0, 32'h3F, 32'h0, 32'h0000_0044, 1'b0);
    xfer("ld_h3f",    1'b0, 2'b01, 1'b0, 32'h3F, 32'h0, 32'h0, 1'b1);
    xfer("st_b50",    1'b1, 2'b00, 1'b0, 32'h50, 32'h0000_0055, 32'h0, 1'b1);
    xfer("st_bhi",    1'b1, 2'b00, 1'b0, 32'h8000_0010, 32'h0000_0066, 32'h0, 1'b1);
    xfer("ld_b10_ok", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0000_00A1, 1'b0);
    xfer("ld_b40",    1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);

    // Unaligned accesses.
    xfer("st_w00", 1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0);
`ifdef BE_DATA_MEM_ALIGN_CHECK_EN
    s = 1'b1; e = 32'h0;
`else
    s = 1'b0; e = 32'hF00D_0080;
`endif
    xfer("ld_w02", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, e, s);
    xfer("st_h03", 1'b1, 2'b01, 1'b0, 32'h03, 32'h0000_BEEF, 32'h0, s);
`ifdef BE_DATA_MEM_ALIGN_CHECK_EN
    xfer("ld_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b0);
    xfer("ld_w04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h0080_0000, 1'b0);
`else
    xfer("ld_w00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 32'hCAFE_F0BE, 1'b0);
    xfer("ld_w04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'hEF80_0000, 1'b0);
`endif

    // Reset with two loads in flight.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    $display("xfer midop: two word loads in flight, reset asserted");
    finish_reset("rst_midop");
    xfer("post_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    xfer("post_w20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/be_data_mem.md
Name: be_data_mem

Overview:
- Parametrised, synchronous, byte-addressable, big-endian data memory for the CPU load/store path.
- Next generation of the team's 32-bit data RAM. Adds:
  - byte, half and word access sizes with sign/zero-extended loads;
  - valid/ready request handshake with pipelined read latency;
  - hardware clear-after-reset sequencer;
  - range and alignment error reporting.
- Sits between the MEM pipeline stage and the hazard unit. The hazard unit stalls on req_ready low.

Parameters:
- DEPTH_BYTES, 1024: memory size in bytes. Must be a power of 2 and a multiple of 4.
- ADDR_W, 32: request address width. Must be ≥ log2(DEPTH_BYTES).
- READ_LAT, 1: load latency in cycles from acceptance to rsp_valid. Legal values 1..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_signed  in  1  load sign-extends when 1, zero-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse per accepted request.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid.
- init_busy  out  1  clear sequencer active.

Behaviour:
- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_busy = 1.
- Reset is synchronous: it flushes all in-flight responses and restarts the clear from word 0. This also applies when reset arrives mid-clear or mid-access.
- FSM state CLEAR (entered on reset):
  - zeroes one 32-bit word per cycle at word index 0..DEPTH_BYTES/4-1;
  - after the last word, moves to IDLE; init_busy falls that same edge.
  - Total clear time is exactly DEPTH_BYTES/4 cycles after rst deasserts.
- FSM state IDLE: req_ready = 1.
  - A request is accepted on any edge where req_valid & req_ready.
  - The block is fully pipelined: one acceptance per cycle, no back-pressure from the response side.
- Byte order is big-endian:
  - word at aligned A = {m[A], m[A+1], m[A+2], m[A+3]};
  - half at A = {m[A], m[A+1]};
  - byte at A = m[A].
- Stores:
  - byte: wdata[7:0] -> m[A];
  - half: wdata[15:8] -> m[A], wdata[7:0] -> m[A+1];
  - word: wdata[31:24] -> m[A] ... wdata[7:0] -> m[A+3].
  - The store commits on the acceptance edge. rsp_valid pulses 1 cycle later with rdata = 0.
- Loads:
  - array read on the acceptance edge;
  - result right-justified and extended per req_signed;
  - rsp_valid exactly READ_LAT cycles after acceptance.
  - A load accepted the cycle after a store to the same bytes returns the stored data; there is no stale read.
- Mixed traffic: when a store and a load complete on the same cycle, responses are kept in acceptance order.
  - Stores use the READ_LAT-deep response pipeline as well, so ordering is always preserved.
  - Consequence: the store response appears READ_LAT cycles after acceptance; the "1 cycle" store latency holds for READ_LAT = 1.
- Errors: rsp_err = 1, no array write, rdata = 0, same latency as a normal access. An error is raised when any of these holds:
  - req_size = 11;
  - A + bytes − 1 ≥ DEPTH_BYTES.
- Address bits above log2(DEPTH_BYTES) must be zero; otherwise the request is an out-of-range error.
- Requests presented while in CLEAR are ignored (req_ready = 0). There is no queueing.

Optional Feature:
- Macro: BE_DATA_MEM_ALIGN_CHECK_EN.
- Defined: a misaligned access raises rsp_err = 1 with no write and rdata = 0. Misaligned means half with A[0] = 1, or word with A[1:0] ≠ 00.
- Not defined: unaligned accesses are legal and access consecutive bytes A..A+n−1 in big-endian order. Range errors still apply.

Test Plan:
- Clear timing: DEPTH_BYTES = 64, pulse rst 1 cycle.
  - init_busy high for exactly 16 cycles, then req_ready = 1.
  - Word load at 0x3C returns 0x00000000.
- Endianness: store word 0xA1B2C3D4 at 0x10.
  - Byte loads at 0x10..0x13 return 0xA1, 0xB2, 0xC3, 0xD4 (unsigned).
  - Half load at 0x12 returns 0x0000C3D4.
- Extension: store byte 0x80 at 0x05.
  - Signed byte load returns 0xFFFFFF80; unsigned returns 0x00000080.
  - Signed half load at 0x04 returns 0x00000080.
- Back-to-back with READ_LAT = 2: store word 0x12345678 at 0x20, then load word 0x20 on the next cycle.
  - Store response at cycle +2, load response at cycle +3 with 0x12345678.
  - No cycle drops req_ready.
- Errors: word access at DEPTH_BYTES−2 and req_size = 11 each give rsp_err = 1 and rdata = 0.
  - Re-reading the target bytes shows them unchanged.
  - With BE_DATA_MEM_ALIGN_CHECK_EN, word at 0x02 errors; without it, the word at 0x02 returns {m[2], m[3], m[4], m[5]}.
- Reset mid-op: assert rst with 2 loads in flight (READ_LAT = 3).
  - No rsp_valid is produced for them.
  - Clear restarts from word 0, so previously stored data reads as 0 afterwards.
